// File: rtl/dm_wb_cache.sv
`default_nettype none
// ============================================================================
// Module  : dm_wb_cache
// Brief   : Direct-mapped, write-back, write-allocate cache with 32-byte lines
//           between a word-level core port and a 256-bit line memory port.
//           Optional macro DM_WB_CACHE_PERF_CNT_EN adds hit/miss counters.
// Revision: 1.0
// ============================================================================
module dm_wb_cache #(
    parameter int S_INDEX = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [3:0]   mem_byte_enable,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    output logic         mem_resp,
    output logic [31:0]  mem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic         pmem_resp,
    input  logic [255:0] pmem_rdata,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
);

    localparam int C_SETS = 2 ** S_INDEX;
    localparam int C_TAGW = 27 - S_INDEX;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RESP = 2'd1,
        S_WB   = 2'd2,
        S_FILL = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [C_SETS-1:0]   r_valid;
    logic [C_SETS-1:0]   r_dirty;
    logic [C_TAGW-1:0]   r_tag  [C_SETS];
    logic [255:0]        r_data [C_SETS];
    logic [31:0]         r_rdata;
    logic [26:0]         r_line;

    logic                w_req;
    logic                w_wr;
    logic [S_INDEX-1:0]  w_idx;
    logic [C_TAGW-1:0]   w_tag;
    logic [2:0]          w_word;
    logic                w_hit;
    logic [S_INDEX-1:0]  w_ridx;
    logic [C_TAGW-1:0]   w_rtag;
    logic                w_unused;

    assign w_req    = mem_read | mem_write;
    assign w_wr     = mem_write;
    assign w_idx    = mem_address[4+S_INDEX:5];
    assign w_tag    = mem_address[31:5+S_INDEX];
    assign w_word   = mem_address[4:2];
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // Miss address is latched so a withdrawn request cannot redirect the line transfer
    assign w_ridx   = r_line[S_INDEX-1:0];
    assign w_rtag   = r_line[26:S_INDEX];
    assign w_unused = ^mem_address[1:0];

    assign mem_resp  = (r_state == S_RESP);
    assign mem_rdata = r_rdata;

    always_comb begin
        w_next       = r_state;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_hit)
                        w_next = S_RESP;
                    else if (r_valid[w_idx] && r_dirty[w_idx])
                        w_next = S_WB;
                    else
                        w_next = S_FILL;
                end
            end
            S_RESP: w_next = S_IDLE;
            S_WB: begin
                pmem_write   = 1'b1;
                pmem_address = {r_tag[w_ridx], w_ridx, 5'b0};
                pmem_wdata   = r_data[w_ridx];
                if (pmem_resp)
                    w_next = S_FILL;
            end
            S_FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {r_line, 5'b0};
                if (pmem_resp)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_valid <= '0;
            r_dirty <= '0;
            r_rdata <= '0;
            r_line  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_req) begin
                r_line <= mem_address[31:5];
                if (w_hit) begin
                    if (w_wr)
                        r_dirty[w_idx] <= 1'b1;
                    else
                        r_rdata <= r_data[w_idx][32*int'(w_word) +: 32];
                end
            end
            if (r_state == S_FILL && pmem_resp) begin
                r_valid[w_ridx] <= 1'b1;
                r_dirty[w_ridx] <= 1'b0;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits gate their use
    always_ff @(posedge clk) begin
        if (rst) begin
            if (r_state == S_IDLE && w_req && w_hit && w_wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byte_enable[b])
                        r_data[w_idx][32*int'(w_word) + 8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
            if (r_state == S_FILL && pmem_resp) begin
                r_data[w_ridx] <= pmem_rdata;
                r_tag[w_ridx]  <= w_rtag;
            end
        end
    end

`ifdef DM_WB_CACHE_PERF_CNT_EN
    logic        r_missed;
    logic [31:0] r_hits;
    logic [31:0] r_misses;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_missed <= 1'b0;
            r_hits   <= '0;
            r_misses <= '0;
        end else if (r_state == S_IDLE && w_req) begin
            if (w_hit) begin
                if (!r_missed)
                    r_hits <= r_hits + 32'd1;
                r_missed <= 1'b0;
            end else begin
                r_misses <= r_misses + 32'd1;
                r_missed <= 1'b1;
            end
        end else if (r_state == S_IDLE) begin
            r_missed <= 1'b0;
        end else if (r_state == S_FILL && pmem_resp) begin
            r_missed <= w_req;
        end
    end

    assign hit_count  = r_hits;
    assign miss_count = r_misses;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule
`default_nettype wire
